memref_stream_reader: RTL and testbench
=======================================

Name: memref_stream_reader

Overview:
- Initiator side of the memref read-port protocol.
- Issues sequential reads to a fixed-latency memref read responder (addr_en/addr_data/rd_en out, rd_data back) and presents the returned words as a valid/ready stream.
- Sits between a memory read port and a streaming compute kernel; also used in benches to drain result memories.
- Credit-based issue, so no word is lost under downstream backpressure.

Parameters:
- WIDTH, 32, data word width
- SIZE, 64, memory depth in words
- ADDR_W, 6, address width (clog2(SIZE))
- RD_LATENCY, 1, cycles from rd_en to valid rd_data (1..4)
- BUF_DEPTH, 4, return FIFO depth; must be >= RD_LATENCY+1

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous active-high reset
- t  in  1  start pulse; sampled only in IDLE
- base  in  ADDR_W  first address, sampled with t
- count  in  ADDR_W+1  number of words, 0..SIZE, sampled with t
- mem_addr_en  out  1  address valid; identical to mem_rd_en
- mem_addr_data  out  ADDR_W  read address
- mem_rd_en  out  1  read request
- mem_rd_data  in  WIDTH  read data, valid RD_LATENCY cycles after mem_rd_en
- out_valid  out  1  stream word valid
- out_data  out  WIDTH  stream word
- out_last  out  1  marks final word of the transfer
- out_ready  in  1  downstream accept
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset: all outputs 0; FSM to IDLE; FIFO emptied; in-flight tags cleared. Reset mid-transfer discards all in-flight and buffered data; no done pulse.
- FSM IDLE -> RUN: on t=1 with count>0. Latch base/count, issued=0, accepted=0, busy=1.
- IDLE with t=1, count=0: busy stays 0; done pulses on the next cycle.
- RUN: each cycle, assert mem_rd_en when all hold:
  - issued<count
  - inflight+fifo_occupancy < BUF_DEPTH
- Address per request: (base+issued) mod SIZE. Wrap from SIZE-1 to 0; ADDR_W+1-bit add, then subtract SIZE if the sum >= SIZE.
- RUN -> DRAIN when issued==count.
- Read return: a RD_LATENCY-deep valid-tag shift register. When a tag exits, mem_rd_data is pushed into the FIFO.
- The credit check guarantees a push never hits a full FIFO. An overflow is an assertion failure.
- Stream: out_valid = FIFO non-empty; out_data = FIFO head, registered.
- Transfer on out_valid & out_ready. out_last=1 on the word where accepted==count-1.
- DRAIN -> IDLE when accepted==count. busy drops and done=1 in that same cycle.
- Latency, start to first word (no backpressure): t at cycle 0, first mem_rd_en at cycle 1, out_valid at cycle 2+RD_LATENCY.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Ordering: words appear in address order. out_data must not change while out_valid & !out_ready.
- t asserted while busy: ignored.
- Simultaneous FIFO push and pop: allowed at any occupancy, including full.
- Simultaneous pop of the last word and a new t: t is ignored (FSM not yet in IDLE).

Optional Feature:
- Macro: MEMREF_RD_STRIDE_EN.
- Defined:
  - Adds input port stride (ADDR_W bits), sampled with t.
  - Request address k = (base + k*stride) mod SIZE, computed by an accumulator with modular wrap.
  - stride=0 re-reads base count times.
- Undefined: no stride port; stride is fixed at 1.

Test Plan:
- Basic: mem[i]=i+100, base=0, count=8, out_ready=1, RD_LATENCY=1.
  - Stream 100..107; out_valid first at cycle 3 after t.
  - out_last on 107; done one cycle later than the last accept.
- Wrap: base=62, count=4, SIZE=64.
  - Addresses 62,63,0,1; data mem[62],mem[63],mem[0],mem[1].
- Backpressure: count=16, out_ready toggled 1,0,0,1 repeating, RD_LATENCY=3, BUF_DEPTH=4.
  - All 16 words in order, none dropped or duplicated; out_data stable while stalled.
  - inflight+occupancy never exceeds 4.
- Edge starts:
  - count=0: done pulse at cycle 1, no mem_rd_en ever.
  - Second t during busy: ignored; exactly count words delivered.
- Reset mid-transfer: rst at the 5th accepted word of count=10.
  - All outputs 0 the next cycle; no done.
  - New t with base=10, count=2 delivers mem[10], mem[11] only.
- MEMREF_RD_STRIDE_EN defined: base=1, stride=20, count=4.
  - Addresses 1,21,41,61.
  - With count=5, the fifth address is 17 (wrap).

Source files
------------

// File: rtl/memref_stream_reader.sv
// -----------------------------------------------------------------------------
// memref_stream_reader
//
// Initiator side of the memref read-port protocol. Issues sequential reads to a
// fixed-latency read responder and re-presents the returned words as a
// valid/ready stream. Issue is credit-based: a request is only made when the
// return FIFO is guaranteed to have room for it, so downstream backpressure
// never loses a word.
//
// Optional feature macro: MEMREF_RD_STRIDE_EN
//   defined   : adds a 'stride' input sampled with t; request k reads
//               (base + k*stride) mod SIZE.
//   undefined : stride is fixed at 1.
//
// Ports:
//   clk            clock, all logic on posedge
//   rst            synchronous active-high reset
//   t              start pulse, only honoured in IDLE
//   base           first address, sampled with t
//   count          number of words (0..SIZE), sampled with t
//   stride         address step, sampled with t (MEMREF_RD_STRIDE_EN only)
//   mem_addr_en    address valid, identical to mem_rd_en
//   mem_addr_data  read address
//   mem_rd_en      read request
//   mem_rd_data    read data, valid RD_LATENCY cycles after mem_rd_en
//   out_valid      stream word valid
//   out_data       stream word (FIFO head)
//   out_last       final word of the transfer
//   out_ready      downstream accept
//   busy           high from start acceptance until done
//   done           one-cycle pulse after the last word is accepted
//
// States:
//   IDLE  | waiting for t
//   RUN   | issuing reads while credit is available
//   DRAIN | all reads issued, waiting for the last word to be accepted
// -----------------------------------------------------------------------------
module memref_stream_reader #(
  parameter int WIDTH      = 32,
  parameter int SIZE       = 64,
  parameter int ADDR_W     = 6,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              t,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
`ifdef MEMREF_RD_STRIDE_EN
  input  logic [ADDR_W-1:0] stride,
`endif
  output logic              mem_addr_en,
  output logic [ADDR_W-1:0] mem_addr_data,
  output logic              mem_rd_en,
  input  logic [WIDTH-1:0]  mem_rd_data,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  // wide enough for inflight + occupancy without overflow
  localparam int CNT_W = $clog2(BUF_DEPTH + RD_LATENCY + 1);
  localparam logic [ADDR_W:0]  SIZE_EXT = (ADDR_W+1)'(SIZE);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   issued_q;
  logic [ADDR_W:0]   accepted_q;
  logic              done_zero_q;
  logic [ADDR_W-1:0] step;

  logic [RD_LATENCY-1:0] tag_q;
  logic [WIDTH-1:0]      buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      occ_q;
  logic [CNT_W-1:0]      inflight;

  logic              issue;
  logic              start;
  logic              start_zero;
  logic              finish;
  logic              credit_ok;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic [ADDR_W:0]   addr_sum;
  logic [ADDR_W-1:0] addr_next;
  logic [ADDR_W:0]   last_idx;

`ifdef MEMREF_RD_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stride_q <= '0;
    end else if (start) begin
      stride_q <= stride;
    end
  end

  assign step = stride_q;
`else
  assign step = ADDR_W'(1);
`endif

  // Both operands are below SIZE, so a single conditional subtract wraps.
  assign addr_sum  = {1'b0, addr_q} + {1'b0, step};
  assign addr_next = (addr_sum >= SIZE_EXT) ? ADDR_W'(addr_sum - SIZE_EXT)
                                            : addr_sum[ADDR_W-1:0];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CNT_W'(tag_q[i]);
    end
  end

  // A tag leaving the shift register this cycle is still counted, and a pop
  // this cycle is not credited, so the check is conservative by design.
  assign credit_ok  = (inflight + occ_q) < DEPTH_C;
  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == DEPTH_C);
  assign push       = tag_q[RD_LATENCY-1];
  assign pop        = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    start      = 1'b0;
    start_zero = 1'b0;
    finish     = 1'b0;
    case (state_q)
      IDLE: begin
        if (t) begin
          if (count != '0) begin
            state_d = RUN;
            start   = 1'b1;
          end else begin
            start_zero = 1'b1;
          end
        end
      end
      RUN: begin
        if ((issued_q < cnt_q) && credit_ok) begin
          issue = 1'b1;
        end
        if (issued_q == cnt_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (accepted_q == cnt_q) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      issued_q    <= '0;
      accepted_q  <= '0;
      done_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_zero_q <= start_zero;
      if (start) begin
        addr_q     <= base;
        cnt_q      <= count;
        issued_q   <= '0;
        accepted_q <= '0;
      end else begin
        if (issue) begin
          addr_q   <= addr_next;
          issued_q <= issued_q + 1'b1;
        end
        if (pop) begin
          accepted_q <= accepted_q + 1'b1;
        end
      end
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Read-return tracking and return FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_mem[i] <= '0;
      end
    end else begin
      tag_q[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      if (push) begin
        buf_mem[wr_ptr_q] <= mem_rd_data;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
      if (push && !pop) begin
        assert (!fifo_full);
      end
    end
  end

  assign last_idx = cnt_q - (ADDR_W+1)'(1);

  assign mem_rd_en     = issue;
  assign mem_addr_en   = issue;
  assign mem_addr_data = issue ? addr_q : '0;
  assign out_valid     = !fifo_empty;
  assign out_data      = buf_mem[rd_ptr_q];
  assign out_last      = out_valid && (accepted_q == last_idx);
  assign busy          = (state_q == RUN) || ((state_q == DRAIN) && !finish);
  assign done          = finish || done_zero_q;

endmodule

// File: tb/tb_memref_stream_reader.sv
module tb_memref_stream_reader;

  localparam int LAT = 3;
  localparam int BD  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        t;
  logic [5:0]  base;
  logic [6:0]  count;
`ifdef MEMREF_RD_STRIDE_EN
  logic [5:0]  stride;
`endif
  logic        mem_addr_en;
  logic [5:0]  mem_addr_data;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  int          exp_addr [$];
  logic [31:0] exp_data [$];
  bit          exp_last [$];

  int          outstanding = 0;
  int          n_acc = 0;
  bit          done_pending = 0;
  bit          zero_req = 0;
  bit          hold_active = 0;
  logic [31:0] hold_data = '0;
  bit          bp_mode = 0;

  memref_stream_reader #(
    .WIDTH(32), .SIZE(64), .ADDR_W(6), .RD_LATENCY(LAT), .BUF_DEPTH(BD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .t(t),
    .base(base),
    .count(count),
`ifdef MEMREF_RD_STRIDE_EN
    .stride(stride),
`endif
    .mem_addr_en(mem_addr_en),
    .mem_addr_data(mem_addr_data),
    .mem_rd_en(mem_rd_en),
    .mem_rd_data(mem_rd_data),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_last(out_last),
    .out_ready(out_ready),
    .busy(busy),
    .done(done)
  );

  initial forever #5 clk = ~clk;

  // Fixed-latency responder model: mem[i] = i + 100.
  logic [31:0]    mem [64];
  logic [LAT-1:0] pv;
  logic [5:0]     pa [LAT];

  always @(posedge clk) begin
    if (rst) pv <= '0;
    else     pv <= {pv[LAT-2:0], mem_rd_en};
    pa[0] <= mem_addr_data;
    for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
  end

  assign mem_rd_data = pv[LAT-1] ? mem[pa[LAT-1]] : 32'hDEAD_BEEF;

  // Downstream ready pattern 1,0,0,1 when backpressure is enabled.
  initial begin : ready_drv
    int ph;
    bit pat [4];
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        out_ready = pat[ph];
        ph = (ph + 1) % 4;
      end else begin
        out_ready = 1'b1;
        ph = 0;
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    int          a;
    logic [31:0] d;
    bit          l;
    if (rst) begin
      exp_addr.delete();
      exp_data.delete();
      exp_last.delete();
      outstanding  = 0;
      done_pending = 0;
      zero_req     = 0;
      hold_active  = 0;
    end else begin
      if (done || done_pending) begin
        tests++;
        if (done !== done_pending) begin
          fails++;
          $display("FAIL done: got %0b need %0b", done, done_pending);
        end
      end
      done_pending = zero_req;
      zero_req = 0;

      if (mem_rd_en) begin
        tests++;
        if (exp_addr.size() == 0) begin
          fails++;
          $display("FAIL addr: unexpected read of %0d, need no read", mem_addr_data);
        end else begin
          a = exp_addr.pop_front();
          if (mem_addr_data !== 6'(a) || mem_addr_en !== 1'b1) begin
            fails++;
            $display("FAIL addr: got %0d en=%0b need %0d en=1", mem_addr_data, mem_addr_en, a);
          end
        end
        outstanding++;
      end

      if (hold_active && out_valid) begin
        tests++;
        if (out_data !== hold_data) begin
          fails++;
          $display("FAIL stall_hold: got %h need %h", out_data, hold_data);
        end
      end
      hold_active = out_valid && !out_ready;
      hold_data   = out_data;

      if (out_valid && out_ready) begin
        tests++;
        if (exp_data.size() == 0) begin
          fails++;
          $display("FAIL data: extra word %h, need none", out_data);
        end else begin
          d = exp_data.pop_front();
          l = exp_last.pop_front();
          if (out_data !== d || out_last !== l) begin
            fails++;
            $display("FAIL data: got %h last=%0b need %h last=%0b", out_data, out_last, d, l);
          end
          if (l) done_pending = 1;
        end
        outstanding--;
        n_acc++;
      end

      if (busy) begin
        tests++;
        if (outstanding > BD) begin
          fails++;
          $display("FAIL credit: outstanding %0d, need <= %0d", outstanding, BD);
        end
      end
    end
  end

  task automatic start_xfer(input int b, input int n, input int s);
    @(posedge clk);
    #1;
    for (int k = 0; k < n; k++) begin
      exp_addr.push_back((b + k * s) % 64);
      exp_data.push_back(32'(((b + k * s) % 64) + 100));
      exp_last.push_back(k == n - 1);
    end
    if (n == 0) zero_req = 1;
    t = 1'b1;
    base = 6'(b);
    count = 7'(n);
`ifdef MEMREF_RD_STRIDE_EN
    stride = 6'(s);
`endif
    @(posedge clk);
    #1;
    t = 1'b0;
    tests++;
    if (busy !== (n != 0)) begin
      fails++;
      $display("FAIL busy_start: got %0b need %0b", busy, (n != 0));
    end
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    while ((busy || exp_data.size() != 0 || exp_addr.size() != 0) && guard < 400) begin
      @(posedge clk);
      #1;
      guard++;
    end
    tests++;
    if (guard >= 400) begin
      fails++;
      $display("FAIL %s timeout: busy=%0b words left=%0d, need idle with 0 left",
               name, busy, exp_data.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    tests++;
    if ({mem_rd_en, mem_addr_en, mem_addr_data, out_valid, out_data, out_last, busy, done} !== '0) begin
      fails++;
      $display("FAIL %s: rd_en=%0b addr=%0d valid=%0b data=%h last=%0b busy=%0b done=%0b, need all 0",
               name, mem_rd_en, mem_addr_data, out_valid, out_data, out_last, busy, done);
    end
  endtask

  initial begin : stim
    int lat;
    int target;
    int guard;
    for (int i = 0; i < 64; i++) mem[i] = 32'(i + 100);
    rst = 1'b1;
    t = 1'b0;
    base = '0;
    count = '0;
`ifdef MEMREF_RD_STRIDE_EN
    stride = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst = 1'b0;

    // Basic transfer and start-to-first-word latency.
    start_xfer(0, 8, 1);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    tests++;
    if (lat != 2 + LAT) begin
      fails++;
      $display("FAIL first_valid_latency: got %0d need %0d", lat, 2 + LAT);
    end
    wait_idle("basic");

    // Address wrap at SIZE-1.
    start_xfer(62, 4, 1);
    wait_idle("wrap");

    // Backpressure with ready pattern 1,0,0,1.
    bp_mode = 1;
    start_xfer(20, 16, 1);
    wait_idle("backpressure");
    bp_mode = 0;

    // Full-depth transfer with wrap.
    start_xfer(3, 64, 1);
    wait_idle("full_size");

    // Zero-count start: done only, no reads.
    start_xfer(0, 0, 1);
    wait_idle("zero_count");

    // Second start while busy is ignored.
    start_xfer(5, 3, 1);
    t = 1'b1;
    base = 6'd40;
    count = 7'd6;
    @(posedge clk);
    #1;
    t = 1'b0;
    wait_idle("second_t");

    // Reset in the middle of a transfer.
    start_xfer(0, 10, 1);
    target = n_acc + 5;
    guard = 0;
    while (n_acc < target && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    tests++;
    if (guard >= 200) begin
      fails++;
      $display("FAIL reset_mid wait: accepted %0d need %0d", n_acc, target);
    end
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("reset_mid_outputs");
    rst = 1'b0;
    start_xfer(10, 2, 1);
    wait_idle("after_reset");

`ifdef MEMREF_RD_STRIDE_EN
    start_xfer(1, 5, 20);
    wait_idle("stride");
    start_xfer(7, 3, 0);
    wait_idle("stride_zero");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
